// File: rtl/minisrc_pkg.sv
// Shared Mini SRC definitions: opcodes, sequencer states, decoded opcode classes
// and the bundle of control lines driven by control_sequencer.
package minisrc_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_MFHI = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD = OP_ADD;

  typedef enum logic [3:0] {
    ST_RESET = 4'd0,
    ST_T0    = 4'd1,
    ST_T1    = 4'd2,
    ST_T2    = 4'd3,
    ST_T3    = 4'd4,
    ST_T4    = 4'd5,
    ST_T5    = 4'd6,
    ST_T6    = 4'd7,
    ST_T7    = 4'd8,
    ST_HALT  = 4'd9
  } state_e;

  // One-hot instruction class; exactly one field is set for any opcode.
  typedef struct packed {
    logic alu_rr;
    logic alu_imm;
    logic unary;
    logic muldiv;
    logic ld;
    logic ldi;
    logic st;
    logic br;
    logic jr;
    logic io_in;
    logic io_out;
    logic mflo;
    logic mfhi;
    logic nop;
    logic halt;
  } cls_t;

  typedef struct packed {
    logic       gra;
    logic       grb;
    logic       grc;
    logic       rin;
    logic       rout;
    logic       baout;
    logic       pcin;
    logic       pcout;
    logic       incpc;
    logic       marin;
    logic       mdrin;
    logic       mdrout;
    logic       read;
    logic       write;
    logic       irin;
    logic       yin;
    logic       zin;
    logic       zlowout;
    logic       zhighout;
    logic       hiin;
    logic       hiout;
    logic       loin;
    logic       loout;
    logic       cout;
    logic       conin;
    logic       inportout;
    logic       outportin;
    logic [4:0] alu_op;
    logic       run;
  } ctrl_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Instruction/condition inputs and datapath control lines between the
// sequencer (master) and the Mini SRC datapath (slave).
interface control_sequencer_if;
  logic [31:0] IR;
  logic        CON;
  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic PCin, PCout, IncPC;
  logic MARin, MDRin, MDRout, Read, Write;
  logic IRin, Yin, Zin, Zlowout, Zhighout;
  logic HIin, HIout, LOin, LOout;
  logic Cout, CONin, InPortout, OutPortin;
  logic [4:0] alu_op;
  logic run;

  modport master (
    input  IR, CON,
    output Gra, Grb, Grc, Rin, Rout, BAout, PCin, PCout, IncPC,
           MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin, Zlowout, Zhighout,
           HIin, HIout, LOin, LOout, Cout, CONin, InPortout, OutPortin, alu_op, run
  );

  modport slave (
    output IR, CON,
    input  Gra, Grb, Grc, Rin, Rout, BAout, PCin, PCout, IncPC,
           MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin, Zlowout, Zhighout,
           HIin, HIout, LOin, LOout, Cout, CONin, InPortout, OutPortin, alu_op, run
  );
endinterface

// File: rtl/control_sequencer_decode.sv
// Maps a 5-bit opcode to its one-hot execution class; unassigned opcodes
// fall into the nop class.
module opcode_class_decode
  import minisrc_pkg::*;
(
  input  logic [4:0] opcode_i,
  output cls_t       cls_o
);

  always_comb begin
    cls_o = '0;
    unique case (opcode_i)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL:       cls_o.alu_rr  = 1'b1;
      OP_ADDI, OP_ANDI, OP_ORI:              cls_o.alu_imm = 1'b1;
      OP_NEG, OP_NOT:                        cls_o.unary   = 1'b1;
      OP_MUL, OP_DIV:                        cls_o.muldiv  = 1'b1;
      OP_LD:                                 cls_o.ld      = 1'b1;
      OP_LDI:                                cls_o.ldi     = 1'b1;
      OP_ST:                                 cls_o.st      = 1'b1;
      OP_BR:                                 cls_o.br      = 1'b1;
      OP_JR:                                 cls_o.jr      = 1'b1;
      OP_IN:                                 cls_o.io_in   = 1'b1;
      OP_OUT:                                cls_o.io_out  = 1'b1;
      OP_MFLO:                               cls_o.mflo    = 1'b1;
      OP_MFHI:                               cls_o.mfhi    = 1'b1;
      OP_HALT:                               cls_o.halt    = 1'b1;
      default:                               cls_o.nop     = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Mini SRC control unit: steps fetch T0-T2 and execute T3-T7, with
// every control line a Moore decode of the current step and the IR class.
module control_sequencer
  import minisrc_pkg::*;
(
  input  logic                clock,
  input  logic                reset_n,
  control_sequencer_if.master bus,
  output state_e              state_o
);

  state_e     state_q, state_d;
  cls_t       cls;
  ctrl_t      ctrl;
  logic [4:0] opcode;

  assign opcode  = bus.IR[31:27];
  assign state_o = state_q;

  opcode_class_decode u_decode (
    .opcode_i (opcode),
    .cls_o    (cls)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_RESET;
    else          state_q <= state_d;
  end

  // nop and halt leave at T2 on the IR value presented during that step.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RESET: state_d = ST_T0;
      ST_T0:    state_d = ST_T1;
      ST_T1:    state_d = ST_T2;
      ST_T2:    state_d = cls.halt ? ST_HALT : (cls.nop ? ST_T0 : ST_T3);
      ST_T3:    state_d = (cls.jr || cls.io_in || cls.io_out || cls.mflo || cls.mfhi)
                          ? ST_T0 : ST_T4;
      ST_T4:    state_d = cls.unary ? ST_T0 : ST_T5;
      ST_T5:    state_d = (cls.alu_rr || cls.alu_imm || cls.ldi) ? ST_T0 : ST_T6;
      ST_T6:    state_d = (cls.muldiv || cls.br) ? ST_T0 : ST_T7;
      ST_T7:    state_d = ST_T0;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_RESET;
    endcase
  end

  always_comb begin
    ctrl     = '0;
    ctrl.run = (state_q != ST_RESET) && (state_q != ST_HALT);
    unique case (state_q)
      ST_T0: begin
        ctrl.pcout = 1'b1; ctrl.marin = 1'b1; ctrl.incpc = 1'b1; ctrl.zin = 1'b1;
      end
      ST_T1: begin
        ctrl.zlowout = 1'b1; ctrl.pcin = 1'b1; ctrl.read = 1'b1; ctrl.mdrin = 1'b1;
      end
      ST_T2: begin
        ctrl.mdrout = 1'b1; ctrl.irin = 1'b1;
      end
      ST_T3: begin
        if (cls.alu_rr || cls.alu_imm) begin
          ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.yin = 1'b1;
        end else if (cls.unary) begin
          ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.zin = 1'b1; ctrl.alu_op = opcode;
        end else if (cls.muldiv) begin
          ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.yin = 1'b1;
        end else if (cls.ld || cls.ldi || cls.st) begin
          ctrl.grb = 1'b1; ctrl.baout = 1'b1; ctrl.yin = 1'b1;
        end else if (cls.br) begin
          ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.conin = 1'b1;
        end else if (cls.jr) begin
          ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.pcin = 1'b1;
        end else if (cls.io_in) begin
          ctrl.inportout = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1;
        end else if (cls.io_out) begin
          ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.outportin = 1'b1;
        end else if (cls.mflo) begin
          ctrl.loout = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1;
        end else if (cls.mfhi) begin
          ctrl.hiout = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1;
        end
      end
      ST_T4: begin
        if (cls.alu_rr) begin
          ctrl.grc = 1'b1; ctrl.rout = 1'b1; ctrl.zin = 1'b1; ctrl.alu_op = opcode;
        end else if (cls.alu_imm) begin
          ctrl.cout = 1'b1; ctrl.zin = 1'b1; ctrl.alu_op = opcode;
        end else if (cls.unary) begin
          ctrl.zlowout = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1;
        end else if (cls.muldiv) begin
          ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.zin = 1'b1; ctrl.alu_op = opcode;
        end else if (cls.ld || cls.ldi || cls.st) begin
          ctrl.cout = 1'b1; ctrl.zin = 1'b1; ctrl.alu_op = ALU_ADD;
        end else if (cls.br) begin
          ctrl.pcout = 1'b1; ctrl.yin = 1'b1;
        end
      end
      ST_T5: begin
        if (cls.alu_rr || cls.alu_imm || cls.ldi) begin
          ctrl.zlowout = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1;
        end else if (cls.muldiv) begin
          ctrl.zlowout = 1'b1; ctrl.loin = 1'b1;
        end else if (cls.ld || cls.st) begin
          ctrl.zlowout = 1'b1; ctrl.marin = 1'b1;
        end else if (cls.br) begin
          ctrl.cout = 1'b1; ctrl.zin = 1'b1; ctrl.alu_op = ALU_ADD;
        end
      end
      ST_T6: begin
        if (cls.muldiv) begin
          ctrl.zhighout = 1'b1; ctrl.hiin = 1'b1;
        end else if (cls.ld) begin
          ctrl.read = 1'b1; ctrl.mdrin = 1'b1;
        end else if (cls.st) begin
          ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.mdrin = 1'b1;
        end else if (cls.br && bus.CON) begin
          ctrl.zlowout = 1'b1; ctrl.pcin = 1'b1;
        end
      end
      ST_T7: begin
        if (cls.ld) begin
          ctrl.mdrout = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1;
        end else if (cls.st) begin
          ctrl.write = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.Gra       = ctrl.gra;
  assign bus.Grb       = ctrl.grb;
  assign bus.Grc       = ctrl.grc;
  assign bus.Rin       = ctrl.rin;
  assign bus.Rout      = ctrl.rout;
  assign bus.BAout     = ctrl.baout;
  assign bus.PCin      = ctrl.pcin;
  assign bus.PCout     = ctrl.pcout;
  assign bus.IncPC     = ctrl.incpc;
  assign bus.MARin     = ctrl.marin;
  assign bus.MDRin     = ctrl.mdrin;
  assign bus.MDRout    = ctrl.mdrout;
  assign bus.Read      = ctrl.read;
  assign bus.Write     = ctrl.write;
  assign bus.IRin      = ctrl.irin;
  assign bus.Yin       = ctrl.yin;
  assign bus.Zin       = ctrl.zin;
  assign bus.Zlowout   = ctrl.zlowout;
  assign bus.Zhighout  = ctrl.zhighout;
  assign bus.HIin      = ctrl.hiin;
  assign bus.HIout     = ctrl.hiout;
  assign bus.LOin      = ctrl.loin;
  assign bus.LOout     = ctrl.loout;
  assign bus.Cout      = ctrl.cout;
  assign bus.CONin     = ctrl.conin;
  assign bus.InPortout = ctrl.inportout;
  assign bus.OutPortin = ctrl.outportin;
  assign bus.alu_op    = ctrl.alu_op;
  assign bus.run       = ctrl.run;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle expected control vectors are
// queued per instruction and compared as the sequencer steps through them.
module tb_control_sequencer;
  import minisrc_pkg::*;

  localparam int W = 33;

  localparam logic [W-1:0] M_GRA   = 33'h1 << 0;
  localparam logic [W-1:0] M_GRB   = 33'h1 << 1;
  localparam logic [W-1:0] M_GRC   = 33'h1 << 2;
  localparam logic [W-1:0] M_RIN   = 33'h1 << 3;
  localparam logic [W-1:0] M_ROUT  = 33'h1 << 4;
  localparam logic [W-1:0] M_BAOUT = 33'h1 << 5;
  localparam logic [W-1:0] M_PCIN  = 33'h1 << 6;
  localparam logic [W-1:0] M_PCOUT = 33'h1 << 7;
  localparam logic [W-1:0] M_INCPC = 33'h1 << 8;
  localparam logic [W-1:0] M_MARIN = 33'h1 << 9;
  localparam logic [W-1:0] M_MDRIN = 33'h1 << 10;
  localparam logic [W-1:0] M_MDROUT= 33'h1 << 11;
  localparam logic [W-1:0] M_READ  = 33'h1 << 12;
  localparam logic [W-1:0] M_WRITE = 33'h1 << 13;
  localparam logic [W-1:0] M_IRIN  = 33'h1 << 14;
  localparam logic [W-1:0] M_YIN   = 33'h1 << 15;
  localparam logic [W-1:0] M_ZIN   = 33'h1 << 16;
  localparam logic [W-1:0] M_ZLO   = 33'h1 << 17;
  localparam logic [W-1:0] M_ZHI   = 33'h1 << 18;
  localparam logic [W-1:0] M_HIIN  = 33'h1 << 19;
  localparam logic [W-1:0] M_HIOUT = 33'h1 << 20;
  localparam logic [W-1:0] M_LOIN  = 33'h1 << 21;
  localparam logic [W-1:0] M_LOOUT = 33'h1 << 22;
  localparam logic [W-1:0] M_COUT  = 33'h1 << 23;
  localparam logic [W-1:0] M_CONIN = 33'h1 << 24;
  localparam logic [W-1:0] M_INP   = 33'h1 << 25;
  localparam logic [W-1:0] M_OUTP  = 33'h1 << 26;
  localparam logic [W-1:0] M_RUN   = 33'h1 << 27;

  logic   clock;
  logic   reset_n;
  state_e state_o;

  control_sequencer_if bus ();

  control_sequencer dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus),
    .state_o (state_o)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic [W-1:0] obs;
  logic [9:0]   bus_drv;

  assign obs = {bus.alu_op, bus.run, bus.OutPortin, bus.InPortout, bus.CONin, bus.Cout,
                bus.LOout, bus.LOin, bus.HIout, bus.HIin, bus.Zhighout, bus.Zlowout,
                bus.Zin, bus.Yin, bus.IRin, bus.Write, bus.Read, bus.MDRout, bus.MDRin,
                bus.MARin, bus.IncPC, bus.PCout, bus.PCin, bus.BAout, bus.Rout, bus.Rin,
                bus.Grc, bus.Grb, bus.Gra};
  assign bus_drv = {bus.Rout, bus.BAout, bus.PCout, bus.MDRout, bus.Zlowout, bus.Zhighout,
                    bus.HIout, bus.LOout, bus.InPortout, bus.Cout};

  function automatic logic [W-1:0] alu(input logic [4:0] op);
    return {op, 28'h0};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // At most one source may drive the internal bus in any cycle.
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      checks++;
      assert ($countones(bus_drv) <= 1) else begin
        errors++;
        $error("FAIL bus_conflict observed=%b expected=at most one", bus_drv);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic [W-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic push_fetch();
    push(M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZIN);
    push(M_RUN | M_ZLO | M_PCIN | M_READ | M_MDRIN);
    push(M_RUN | M_MDROUT | M_IRIN);
  endtask

  task automatic push_ld_addr();
    push(M_RUN | M_GRB | M_BAOUT | M_YIN);
    push(M_RUN | M_COUT | M_ZIN | alu(OP_ADD));
  endtask

  // Called just after the edge that entered T0; pops one expected vector per cycle.
  task automatic run_cycles(input string tag, input int n);
    logic [W-1:0] e;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0) begin
        check({tag, "_queue_empty"}, obs, '1);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s_c%0d", tag, i), obs, e);
      end
      @(posedge clock);
      #1;
    end
  endtask

  task automatic run_instr(input string tag, input logic [31:0] ir, input logic con,
                           input state_e end_state);
    int n;
    bus.IR  = ir;
    bus.CON = con;
    n = exp_q.size();
    run_cycles(tag, n);
    check({tag, "_end_state"}, W'(state_o), W'(end_state));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset_n = 1'b0;
    bus.IR  = 32'h0;
    bus.CON = 1'b0;

    repeat (3) begin
      @(negedge clock);
      check("reset_outputs", obs, '0);
      check("reset_state", W'(state_o), W'(ST_RESET));
    end
    reset_n = 1'b1;
    #1;
    check("reset_release_outputs", obs, '0);
    @(posedge clock);
    #1;
    check("first_edge_t0", W'(state_o), W'(ST_T0));

    // add R1,R2,R3
    push_fetch();
    push(M_RUN | M_GRB | M_ROUT | M_YIN);
    push(M_RUN | M_GRC | M_ROUT | M_ZIN | alu(OP_ADD));
    push(M_RUN | M_ZLO | M_GRA | M_RIN);
    run_instr("add", 32'h18918000, 1'b0, ST_T0);

    // shra: opcode drives alu_op
    push_fetch();
    push(M_RUN | M_GRB | M_ROUT | M_YIN);
    push(M_RUN | M_GRC | M_ROUT | M_ZIN | alu(OP_SHRA));
    push(M_RUN | M_ZLO | M_GRA | M_RIN);
    run_instr("shra", {OP_SHRA, 27'h0123456}, 1'b0, ST_T0);

    // ld
    push_fetch();
    push_ld_addr();
    push(M_RUN | M_ZLO | M_MARIN);
    push(M_RUN | M_READ | M_MDRIN);
    push(M_RUN | M_MDROUT | M_GRA | M_RIN);
    run_instr("ld", 32'h00800005, 1'b0, ST_T0);

    // ldi
    push_fetch();
    push_ld_addr();
    push(M_RUN | M_ZLO | M_GRA | M_RIN);
    run_instr("ldi", {OP_LDI, 27'h0800010}, 1'b0, ST_T0);

    // st
    push_fetch();
    push_ld_addr();
    push(M_RUN | M_ZLO | M_MARIN);
    push(M_RUN | M_GRA | M_ROUT | M_MDRIN);
    push(M_RUN | M_WRITE);
    run_instr("st", {OP_ST, 27'h0880007}, 1'b0, ST_T0);

    // addi
    push_fetch();
    push(M_RUN | M_GRB | M_ROUT | M_YIN);
    push(M_RUN | M_COUT | M_ZIN | alu(OP_ADDI));
    push(M_RUN | M_ZLO | M_GRA | M_RIN);
    run_instr("addi", {OP_ADDI, 27'h0900003}, 1'b0, ST_T0);

    // neg
    push_fetch();
    push(M_RUN | M_GRB | M_ROUT | M_ZIN | alu(OP_NEG));
    push(M_RUN | M_ZLO | M_GRA | M_RIN);
    run_instr("neg", {OP_NEG, 27'h0880000}, 1'b0, ST_T0);

    // mul: LO then HI, no Rin
    push_fetch();
    push(M_RUN | M_GRA | M_ROUT | M_YIN);
    push(M_RUN | M_GRB | M_ROUT | M_ZIN | alu(OP_MUL));
    push(M_RUN | M_ZLO | M_LOIN);
    push(M_RUN | M_ZHI | M_HIIN);
    run_instr("mul", {OP_MUL, 27'h0100000}, 1'b0, ST_T0);

    // br with CON=0 then CON=1
    for (int c = 0; c < 2; c++) begin
      push_fetch();
      push(M_RUN | M_GRA | M_ROUT | M_CONIN);
      push(M_RUN | M_PCOUT | M_YIN);
      push(M_RUN | M_COUT | M_ZIN | alu(OP_ADD));
      push((c == 1) ? (M_RUN | M_ZLO | M_PCIN) : M_RUN);
      run_instr($sformatf("br_con%0d", c), {OP_BR, 27'h0080004}, c[0], ST_T0);
    end

    // single-step execute instructions
    push_fetch(); push(M_RUN | M_GRA | M_ROUT | M_PCIN);
    run_instr("jr", {OP_JR, 27'h0800000}, 1'b0, ST_T0);
    push_fetch(); push(M_RUN | M_INP | M_GRA | M_RIN);
    run_instr("in", {OP_IN, 27'h0800000}, 1'b0, ST_T0);
    push_fetch(); push(M_RUN | M_GRA | M_ROUT | M_OUTP);
    run_instr("out", {OP_OUT, 27'h0800000}, 1'b0, ST_T0);
    push_fetch(); push(M_RUN | M_LOOUT | M_GRA | M_RIN);
    run_instr("mflo", {OP_MFLO, 27'h1000000}, 1'b0, ST_T0);
    push_fetch(); push(M_RUN | M_HIOUT | M_GRA | M_RIN);
    run_instr("mfhi", {OP_MFHI, 27'h1000000}, 1'b0, ST_T0);

    // nop and a reserved opcode: fetch only
    push_fetch();
    run_instr("nop", {OP_NOP, 27'h0}, 1'b0, ST_T0);
    push_fetch();
    run_instr("reserved", {5'b10100, 27'h7ffffff}, 1'b0, ST_T0);

    // halt holds with everything low
    push_fetch();
    run_instr("halt", {OP_HALT, 27'h0}, 1'b0, ST_HALT);
    bus.IR = {OP_ADD, 27'h0}; // must not wake it up
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check($sformatf("halt_hold_out_%0d", i), obs, '0);
      check($sformatf("halt_hold_state_%0d", i), W'(state_o), W'(ST_HALT));
    end
    reset_n = 1'b0;
    #1;
    check("halt_reset_state", W'(state_o), W'(ST_RESET));
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("halt_restart_t0", W'(state_o), W'(ST_T0));

    // st aborted by reset in T4: Write never appears
    push_fetch();
    push_ld_addr();
    bus.IR  = {OP_ST, 27'h0880007};
    bus.CON = 1'b0;
    run_cycles("st_abort", 4);
    check("st_abort_in_t4", W'(state_o), W'(ST_T4));
    @(negedge clock);
    check("st_abort_t4_out", obs, exp_q.pop_front());
    #2;
    reset_n = 1'b0;
    #1;
    check("st_abort_out_zero", obs, '0);
    check("st_abort_state", W'(state_o), W'(ST_RESET));
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check($sformatf("st_abort_write_%0d", i), W'(bus.Write), '0);
    end
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("st_abort_restart_t0", W'(state_o), W'(ST_T0));

    check("queue_drained", W'(exp_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog: the directed sequence is a few hundred cycles at most.
  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
